// File: rtl/calc_pkg.sv
// Shared state/operator codes for the BCD calculator sequencer.
package calc_pkg;

    typedef enum logic [3:0] {
        ST_A    = 4'd1,
        ST_ADD  = 4'd2,
        ST_SUB  = 4'd3,
        ST_MUL  = 4'd4,
        ST_DIV  = 4'd5,
        ST_BUSY = 4'd6,
        ST_TEST = 4'd7,
        ST_ERR  = 4'd8
    } calc_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    function automatic calc_op_t state_to_op(input calc_state_t s);
        case (s)
            ST_SUB:  return OP_SUB;
            ST_MUL:  return OP_MUL;
            ST_DIV:  return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic calc_state_t op_to_state(input calc_op_t op);
        case (op)
            OP_SUB:  return ST_SUB;
            OP_MUL:  return ST_MUL;
            OP_DIV:  return ST_DIV;
            default: return ST_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_wait_timer.sv
// Clear/enable up-counter measuring cycles since op_start; holds at TERM.
module calc_wait_timer #(
    parameter int unsigned TERM  = 1024,
    parameter int unsigned CNT_W = $clog2(TERM + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !at_term) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_term = (count == CNT_W'(TERM));

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: key pulses -> state code, op start, completion routing.
// Optional macro CALC_CHAIN_EN: success returns to ENTER_B with the same operator.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned ADDSUB_LAT  = 2,
    parameter int unsigned MUL_LAT     = 4,
    parameter int unsigned DIV_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_op,
    input  logic       key_eq,
    input  logic       key_clr,
    input  logic       key_test,
    input  logic       alu_err,
    input  logic       div_done,
    input  logic       div_zero,
    output logic [3:0] state,
    output logic [1:0] op_sel,
    output logic       op_start,
    output logic       load_result,
    output logic       clr_operands,
    output logic       busy,
    output logic       error
);

    localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);

    calc_state_t      state_q, state_d, succ_state;
    calc_op_t         op_q, op_d;
    logic             op_start_d, load_result_d, clr_req;
    logic             done, fail;
    logic             timer_clr, timer_en, wait_term;
    logic [CNT_W-1:0] wait_cnt;

    // Counter reads 1 in the op_start cycle, so count==LAT lands the result LAT cycles later.
    assign timer_en  = (state_d == ST_BUSY);
    assign timer_clr = !timer_en;

    calc_wait_timer #(
        .TERM  (DIV_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .count   (wait_cnt),
        .at_term (wait_term)
    );

`ifdef CALC_CHAIN_EN
    assign succ_state = op_to_state(op_q);
`else
    assign succ_state = ST_A;
`endif

    always_comb begin
        done = 1'b0;
        fail = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: done = (wait_cnt == CNT_W'(ADDSUB_LAT));
            OP_MUL:         done = (wait_cnt == CNT_W'(MUL_LAT));
            default: begin
                // div_done in the timeout cycle still wins over the timeout
                done = div_done || wait_term;
                fail = div_zero || !div_done;
            end
        endcase
        fail = fail || alu_err;
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        op_start_d    = 1'b0;
        load_result_d = 1'b0;
        clr_req       = 1'b0;
        case (state_q)
            ST_A: begin
                if (key_clr) begin
                    clr_req = 1'b1;
                end else if (key_test) begin
                    state_d = ST_TEST;
                end else if (key_op && !key_eq) begin
                    state_d = ST_ADD;
                    op_d    = OP_ADD;
                end
            end
            ST_ADD, ST_SUB, ST_MUL, ST_DIV: begin
                if (key_clr) begin
                    state_d = ST_A;
                    clr_req = 1'b1;
                end else if (!key_test) begin
                    if (key_eq) begin
                        state_d    = ST_BUSY;
                        op_start_d = 1'b1;
                    end else if (key_op) begin
                        op_d    = calc_op_t'(state_to_op(state_q) + 2'd1);
                        state_d = op_to_state(op_d);
                    end
                end
            end
            ST_BUSY: begin
                if (key_clr) begin
                    state_d = ST_A;
                    clr_req = 1'b1;
                end else if (done) begin
                    if (fail) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d       = succ_state;
                        load_result_d = 1'b1;
                    end
                end
            end
            ST_TEST: begin
                if (key_clr || key_test) state_d = ST_A;
            end
            ST_ERR: begin
                if (key_clr) begin
                    state_d = ST_A;
                    clr_req = 1'b1;
                end
            end
            default: state_d = ST_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_A;
            op_q         <= OP_ADD;
            op_start     <= 1'b0;
            load_result  <= 1'b0;
            clr_operands <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            op_start     <= op_start_d;
            load_result  <= load_result_d;
            // back-to-back key_clr must not produce a two-cycle clear
            clr_operands <= clr_req && !clr_operands;
            busy         <= (state_d == ST_BUSY);
            error        <= (state_d == ST_ERR);
        end
    end

    assign state  = state_q;
    assign op_sel = op_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scenario bench for calc_seq_ctrl; completion events are scoreboarded by cycle.
module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_op = 1'b0, key_eq = 1'b0, key_clr = 1'b0, key_test = 1'b0;
    logic       alu_err = 1'b0, div_done = 1'b0, div_zero = 1'b0;
    logic [3:0] state;
    logic [1:0] op_sel;
    logic       op_start, load_result, clr_operands, busy, error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int   due;
        logic is_err;
    } exp_t;
    exp_t sb[$];

    calc_seq_ctrl #(
        .ADDSUB_LAT  (2),
        .MUL_LAT     (4),
        .DIV_TIMEOUT (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_op       (key_op),
        .key_eq       (key_eq),
        .key_clr      (key_clr),
        .key_test     (key_test),
        .alu_err      (alu_err),
        .div_done     (div_done),
        .div_zero     (div_zero),
        .state        (state),
        .op_sel       (op_sel),
        .op_start     (op_start),
        .load_result  (load_result),
        .clr_operands (clr_operands),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    // One clock with the given keys held; returns #1 after the edge.
    task automatic cycle(input logic k_op, input logic k_eq, input logic k_clr, input logic k_test);
        key_op   = k_op;
        key_eq   = k_eq;
        key_clr  = k_clr;
        key_test = k_test;
        @(posedge clk);
        #1;
        key_op   = 1'b0;
        key_eq   = 1'b0;
        key_clr  = 1'b0;
        key_test = 1'b0;
        cyc++;
    endtask

    task automatic ops(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Waits for load_result or error; flags = {load_result, error} at that cycle.
    task automatic wait_done(input int limit, output int at, output logic [1:0] flags, output logic timed_out);
        at        = -1;
        flags     = 2'b00;
        timed_out = 1'b1;
        for (int i = 0; i < limit && timed_out; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (load_result || error) begin
                at        = cyc;
                flags     = {load_result, error};
                timed_out = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({state, op_sel, op_start, load_result, clr_operands, busy, error} !== 11'b0001_00_00000) begin
            failures++;
            $display("FAIL reset_values: got state=%0d op_sel=%0d pulses=%b busy=%b error=%b, required state=1 op_sel=0 pulses=000 busy=0 error=0",
                     state, op_sel, {op_start, load_result, clr_operands}, busy, error);
        end
        rst = 1'b0;
    endtask

    task automatic test_addsub();
        int s, at; logic [1:0] fl; logic to; exp_t e;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd2 || op_sel !== 2'd0) begin
            failures++; $display("FAIL addsub_op1: got state=%0d op_sel=%0d, required 2/0", state, op_sel);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd3 || op_sel !== 2'd1) begin
            failures++; $display("FAIL addsub_op2: got state=%0d op_sel=%0d, required 3/1", state, op_sel);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc;
        sb.push_back('{due: s + 2, is_err: 1'b0});
        checks++;
        if (state !== 4'd6 || op_start !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL addsub_start: got state=%0d op_start=%b busy=%b, required 6/1/1", state, op_start, busy);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (op_start !== 1'b0 || state !== 4'd6) begin
            failures++; $display("FAIL addsub_start_width: got op_start=%b state=%0d, required 0/6", op_start, state);
        end
        wait_done(50, at, fl, to);
        e = sb.pop_front();
        checks++;
        if (to || at != e.due || fl !== {~e.is_err, e.is_err} || state !== 4'd1) begin
            failures++; $display("FAIL addsub_complete: got cycle=%0d flags=%b state=%0d timeout=%b, required cycle=%0d flags=10 state=1",
                                 at, fl, state, to, e.due);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (load_result !== 1'b0) begin
            failures++; $display("FAIL addsub_load_width: got load_result=%b, required 0", load_result);
        end
    endtask

    task automatic test_mul_err();
        int s, at; logic [1:0] fl; logic to; exp_t e;
        ops(3);
        checks++;
        if (state !== 4'd4 || op_sel !== 2'd2) begin
            failures++; $display("FAIL mul_select: got state=%0d op_sel=%0d, required 4/2", state, op_sel);
        end
        alu_err = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc;
        sb.push_back('{due: s + 4, is_err: 1'b1});
        wait_done(50, at, fl, to);
        e = sb.pop_front();
        checks++;
        if (to || at != e.due || fl !== {~e.is_err, e.is_err} || state !== 4'd8) begin
            failures++; $display("FAIL mul_err_complete: got cycle=%0d flags=%b state=%0d timeout=%b, required cycle=%0d flags=01 state=8",
                                 at, fl, state, to, e.due);
        end
        alu_err = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (state !== 4'd8 || error !== 1'b1) begin
            failures++; $display("FAIL err_hold: got state=%0d error=%b, required 8/1", state, error);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 4'd1 || clr_operands !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL err_clear: got state=%0d clr=%b error=%b, required 1/1/0", state, clr_operands, error);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ticks_before: idle cycles after op_start before div_done is driven (-1: never)
    task automatic run_div(input string name, input int ticks_before, input logic zero, input int due_ofs, input logic exp_err);
        int s, at; logic [1:0] fl; logic to; exp_t e; logic stray;
        ops(4);
        checks++;
        if (state !== 4'd5 || op_sel !== 2'd3) begin
            failures++; $display("FAIL %s_select: got state=%0d op_sel=%0d, required 5/3", name, state, op_sel);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc;
        sb.push_back('{due: s + due_ofs, is_err: exp_err});
        stray = 1'b0;
        for (int i = 0; i < ticks_before; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (state !== 4'd6 || load_result || error) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++; $display("FAIL %s_early_exit: got premature exit before div_done, required state 6 held", name);
        end
        if (ticks_before >= 0) begin
            div_done = 1'b1;
            div_zero = zero;
        end
        wait_done(1100, at, fl, to);
        div_done = 1'b0;
        div_zero = 1'b0;
        e = sb.pop_front();
        checks++;
        if (to || at != e.due || fl !== {~e.is_err, e.is_err}) begin
            failures++; $display("FAIL %s_complete: got cycle=%0d flags=%b timeout=%b, required cycle=%0d flags=%b",
                                 name, at, fl, to, e.due, {~e.is_err, e.is_err});
        end
        if (error) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_div();
        run_div("div_ok", 36, 1'b0, 37, 1'b0);
        run_div("div_zero", 5, 1'b1, 6, 1'b1);
        run_div("div_timeout", -1, 1'b0, 1024, 1'b1);
        run_div("div_race", 1023, 1'b0, 1024, 1'b0);
    endtask

    task automatic test_clr_priority();
        ops(3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (state !== 4'd1 || clr_operands !== 1'b1 || op_start !== 1'b0) begin
            failures++; $display("FAIL clr_vs_eq: got state=%0d clr=%b op_start=%b, required 1/1/0", state, clr_operands, op_start);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (clr_operands !== 1'b0) begin
            failures++; $display("FAIL clr_back_to_back: got clr_operands=%b, required 0", clr_operands);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd1 || op_start !== 1'b0) begin
            failures++; $display("FAIL eq_in_a: got state=%0d op_start=%b, required 1/0", state, op_start);
        end
    endtask

    task automatic test_test_mode();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 4'd7) begin
            failures++; $display("FAIL test_enter: got state=%0d, required 7", state);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd7 || op_start !== 1'b0) begin
            failures++; $display("FAIL test_hold: got state=%0d op_start=%b, required 7/0", state, op_start);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 4'd1 || clr_operands !== 1'b0) begin
            failures++; $display("FAIL test_leave: got state=%0d clr=%b, required 1/0", state, clr_operands);
        end
    endtask

    task automatic test_rst_mid();
        ops(4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, op_sel, op_start, load_result, clr_operands, busy, error} !== 11'b0001_00_00000) begin
            failures++; $display("FAIL rst_mid_compute: got state=%0d op_sel=%0d pulses=%b busy=%b error=%b, required 1/0/000/0/0",
                                 state, op_sel, {op_start, load_result, clr_operands}, busy, error);
        end
        rst = 1'b0;
        div_done = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        div_done = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd1 || load_result !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL rst_late_done: got state=%0d load=%b error=%b, required 1/0/0", state, load_result, error);
        end
    endtask

    task automatic test_back_to_back();
        int s, at; logic [1:0] fl; logic to; exp_t e;
        ops(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc;
        sb.push_back('{due: s + 2, is_err: 1'b0});
        wait_done(50, at, fl, to);
        e = sb.pop_front();
`ifdef CALC_CHAIN_EN
        checks++;
        if (to || at != e.due || fl !== 2'b10 || state !== 4'd3 || op_sel !== 2'd1) begin
            failures++; $display("FAIL chain_complete: got cycle=%0d flags=%b state=%0d, required cycle=%0d flags=10 state=3", at, fl, state, e.due);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc;
        checks++;
        if (state !== 4'd6 || op_start !== 1'b1) begin
            failures++; $display("FAIL chain_restart: got state=%0d op_start=%b, required 6/1", state, op_start);
        end
        sb.push_back('{due: s + 2, is_err: 1'b0});
        wait_done(50, at, fl, to);
        e = sb.pop_front();
        checks++;
        if (to || at != e.due || fl !== 2'b10) begin
            failures++; $display("FAIL chain_second: got cycle=%0d flags=%b, required cycle=%0d flags=10", at, fl, e.due);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
`else
        checks++;
        if (to || at != e.due || fl !== 2'b10 || state !== 4'd1) begin
            failures++; $display("FAIL b2b_complete: got cycle=%0d flags=%b state=%0d, required cycle=%0d flags=10 state=1", at, fl, state, e.due);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd1 || op_start !== 1'b0) begin
            failures++; $display("FAIL b2b_eq_ignored: got state=%0d op_start=%b, required 1/0", state, op_start);
        end
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul_err();
        test_div();
        test_clr_priority();
        test_test_mode();
        test_rst_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
